tap_delay_line: RTL and testbench

Parametrised multi-tap sample delay line for the pixel-stream front end. It shifts accepted samples through DEPTH registered stages and presents two configurable stage taps as registered outputs. It tracks fill level with a small state machine, so downstream feature logic (corner/ring comparators) sees valid taps only once the line holds DEPTH real samples. It supersedes the fixed 8-bit, 7-stage, two-tap shifter.

---
 rtl/tap_line_pkg.sv | 19 +
 rtl/tap_abs_diff.sv | 45 ++++
 rtl/tap_delay_line.sv | 151 +++++++++++++++
 tb/tb_tap_delay_line.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tap_line_pkg.sv
// Shared definitions for the tap delay line: fill-state encoding and the
// fill-counter width helper.
package tap_line_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Number of bits needed to hold the values 0..depth.
  function automatic int clog2_p1(input int depth);
    int w;
    w = 0;
    while ((1 << w) <= depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/tap_abs_diff.sv
// Registered magnitude and sign of (a - b), plus a valid flag delayed one
// cycle from in_valid. Used only when TAP_DIFF_EN is defined.
module tap_abs_diff #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] abs_diff,
  output logic              diff_sign,
  output logic              diff_valid
);

  logic [DATA_W:0] diff;
  logic [DATA_W:0] mag;
  logic            neg;

  // Extended-width subtraction so the borrow gives the sign directly.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    neg  = diff[DATA_W];
    mag  = neg ? -diff : diff;
  end

  // Diff pipeline stage; clear flushes it alongside the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      abs_diff   <= '0;
      diff_sign  <= 1'b0;
      diff_valid <= 1'b0;
    end else if (clear) begin
      abs_diff   <= '0;
      diff_sign  <= 1'b0;
      diff_valid <= 1'b0;
    end else begin
      abs_diff   <= mag[DATA_W-1:0];
      diff_sign  <= neg;
      diff_valid <= in_valid;
    end
  end

endmodule

// File: rtl/tap_delay_line.sv
// Multi-tap sample delay line with fill tracking.
// Optional feature macro: TAP_DIFF_EN adds the registered |tap_a - tap_b|
// path (abs_diff, diff_sign, diff_valid).
//
// Stream semantics: a sample is taken on every rising edge where
// in_valid=1 and clear=0 (there is no back-pressure). out_valid is a
// one-cycle pulse following each accepted sample once the line is full;
// tap_a/tap_b are meaningful in exactly those cycles.
module tap_delay_line
  import tap_line_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int TAP_A  = 6,
  parameter int TAP_B  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic [DATA_W-1:0]            tap_a,
  output logic [DATA_W-1:0]            tap_b,
  output logic                         out_valid,
  output logic [clog2_p1(DEPTH)-1:0]   fill_cnt,
  output logic                         full,
  output state_t                       fsm_state
`ifdef TAP_DIFF_EN
  ,
  output logic [DATA_W-1:0]            abs_diff,
  output logic                         diff_sign,
  output logic                         diff_valid
`endif
);

  localparam int CNT_W = clog2_p1(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("tap_delay_line: DEPTH must be at least 1");
  end
  if (TAP_A < 1 || TAP_A > DEPTH) begin : g_bad_tap_a
    $error("tap_delay_line: TAP_A must lie in 1..DEPTH");
  end
  if (TAP_B < 1 || TAP_B > DEPTH) begin : g_bad_tap_b
    $error("tap_delay_line: TAP_B must lie in 1..DEPTH");
  end

  logic              accept;
  logic [DATA_W-1:0] stage   [DEPTH];
  logic [DATA_W-1:0] shifted [DEPTH];
  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              valid_next;

  assign accept    = in_valid & ~clear;
  assign full      = (fill_cnt == DEPTH_C);
  assign fsm_state = state;
  assign cnt_inc   = fill_cnt + CNT_W'(1);

  // Post-shift view of the line; index 0 is stage 1.
  always_comb begin
    shifted[0] = in_data;
    for (int k = 1; k < DEPTH; k++) shifted[k] = stage[k-1];
  end

  // Delay stages and tap registers advance together on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      tap_a <= '0;
      tap_b <= '0;
    end else if (clear) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      tap_a <= '0;
      tap_b <= '0;
    end else if (accept) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= shifted[k];
      tap_a <= shifted[TAP_A-1];
      tap_b <= shifted[TAP_B-1];
    end
  end

  // Fill FSM state, counter and out_valid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      fill_cnt  <= cnt_next;
      out_valid <= valid_next;
    end
  end

  // Fill FSM next state: clear wins, otherwise advance on accept.
  always_comb begin
    state_next = state;
    cnt_next   = fill_cnt;
    valid_next = 1'b0;
    if (clear) begin
      state_next = EMPTY;
      cnt_next   = '0;
    end else if (accept) begin
      case (state)
        EMPTY: begin
          cnt_next = CNT_W'(1);
          if (DEPTH == 1) begin
            state_next = RUN;
            valid_next = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
        FILL: begin
          cnt_next = cnt_inc;
          if (cnt_inc == DEPTH_C) begin
            state_next = RUN;
            valid_next = 1'b1;
          end
        end
        RUN: begin
          valid_next = 1'b1;
        end
        default: begin
          state_next = EMPTY;
          cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef TAP_DIFF_EN
  tap_abs_diff #(
    .DATA_W(DATA_W)
  ) u_abs_diff (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (out_valid),
    .a         (tap_a),
    .b         (tap_b),
    .abs_diff  (abs_diff),
    .diff_sign (diff_sign),
    .diff_valid(diff_valid)
  );
`endif

endmodule

// File: tb/tb_tap_delay_line.sv
// Self-checking bench for tap_delay_line: directed scenarios followed by
// random traffic, compared against a queue-based model of the line.
module tb_tap_delay_line;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 7;
  localparam int TAP_A  = 6;
  localparam int TAP_B  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] tap_a, tap_b;
  logic              out_valid;
  logic [2:0]        fill_cnt;
  logic              full;
  tap_line_pkg::state_t fsm_state;
`ifdef TAP_DIFF_EN
  logic [DATA_W-1:0] abs_diff;
  logic              diff_sign;
  logic              diff_valid;
`endif

  tap_delay_line #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TAP_A(TAP_A), .TAP_B(TAP_B)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .tap_a     (tap_a),
    .tap_b     (tap_b),
    .out_valid (out_valid),
    .fill_cnt  (fill_cnt),
    .full      (full),
    .fsm_state (fsm_state)
`ifdef TAP_DIFF_EN
    ,
    .abs_diff  (abs_diff),
    .diff_sign (diff_sign),
    .diff_valid(diff_valid)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds accepted samples, newest first; entry k-1 is stage k.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_tap_a, m_tap_b, m_abs;
  logic              m_ovalid, m_dvalid, m_sign;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_tap_a = '0; m_tap_b = '0; m_ovalid = 1'b0;
    m_abs = '0; m_sign = 1'b0; m_dvalid = 1'b0;
  endtask

  // Model the effect of one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [DATA_W-1:0] d, input logic c);
    logic [DATA_W-1:0] old_a, old_b;
    logic old_ov;
    old_a = m_tap_a; old_b = m_tap_b; old_ov = m_ovalid;
    if (c) begin
      model_reset();
    end else begin
      m_dvalid = old_ov;
      m_sign   = (old_b > old_a);
      m_abs    = m_sign ? old_b - old_a : old_a - old_b;
      if (v) begin
        exp_q.push_front(d);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        m_tap_a  = (exp_q.size() >= TAP_A) ? exp_q[TAP_A-1] : '0;
        m_tap_b  = (exp_q.size() >= TAP_B) ? exp_q[TAP_B-1] : '0;
        m_ovalid = (exp_q.size() == DEPTH);
      end else begin
        m_ovalid = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int cnt, st;
    cnt = exp_q.size();
    st  = (cnt == 0) ? 0 : (cnt < DEPTH) ? 1 : 2;
    check({tag, ".tap_a"},     32'(tap_a),     32'(m_tap_a));
    check({tag, ".tap_b"},     32'(tap_b),     32'(m_tap_b));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_ovalid));
    check({tag, ".fill_cnt"},  32'(fill_cnt),  32'(cnt));
    check({tag, ".full"},      32'(full),      32'(cnt == DEPTH));
    check({tag, ".state"},     32'(fsm_state), 32'(st));
`ifdef TAP_DIFF_EN
    check({tag, ".diff_valid"}, 32'(diff_valid), 32'(m_dvalid));
    check({tag, ".diff_sign"},  32'(diff_sign),  32'(m_sign));
    check({tag, ".abs_diff"},   32'(abs_diff),   32'(m_abs));
`endif
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // at the same point, after the model has absorbed that edge.
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d, input logic c);
    in_valid = v; in_data = d; clear = c;
    @(posedge clk);
    model_edge(v, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; clear = 1'b0;
  endtask

  logic [DATA_W-1:0] diff_seq [DEPTH];

  initial begin
    model_reset();
    // Reset with no clock edge: assert between edges and look immediately.
    #2;
    reset_n = 1'b0;
    #1;
    check_all("reset");
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Continuous fill 1..7, then 8.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DATA_W'(i), 1'b0);
    check("fill7.tap_a", 32'(tap_a), 32'd2);
    check("fill7.tap_b", 32'(tap_b), 32'd6);
    check("fill7.full",  32'(full),  32'd1);
    check("fill7.out_valid", 32'(out_valid), 32'd1);
    step("fill8", 1'b1, 8'd8, 1'b0);
    check("fill8.tap_a", 32'(tap_a), 32'd3);
    check("fill8.tap_b", 32'(tap_b), 32'd7);
    step("fill_idle", 1'b0, 8'd0, 1'b0);

    // Clear, then gapped fill 1..7 with in_valid alternating.
    step("clear0", 1'b0, 8'd0, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      step("gap_acc", 1'b1, DATA_W'(i), 1'b0);
      step("gap_idle", 1'b0, 8'hAA, 1'b0);
    end
    step("gap_acc8", 1'b1, 8'd8, 1'b0);
    step("gap_idle8", 1'b0, 8'd0, 1'b0);

    // Clear at fill_cnt=4 with a competing sample 9.
    step("clear1", 1'b0, 8'd0, 1'b1);
    for (int i = 1; i <= 4; i++) step("pre_clr", 1'b1, DATA_W'(20 + i), 1'b0);
    check("pre_clr.fill_cnt", 32'(fill_cnt), 32'd4);
    step("clr9", 1'b1, 8'd9, 1'b1);
    check("clr9.fill_cnt", 32'(fill_cnt), 32'd0);
    check("clr9.tap_a", 32'(tap_a), 32'd0);
    for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, DATA_W'(40 + i), 1'b0);
    check("refill.out_valid", 32'(out_valid), 32'd1);

    // Reset while out_valid is high.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_run");
    check("rst_run.out_valid", 32'(out_valid), 32'd0);
    idle_inputs();
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_all("rst_rel");
    for (int i = 1; i <= DEPTH; i++) step("rst_refill", 1'b1, DATA_W'(60 + i), 1'b0);

    // Diff scenario: stage6=10, stage2=250 after seven accepts.
    step("clear2", 1'b0, 8'd0, 1'b1);
    diff_seq = '{8'd1, 8'd10, 8'd3, 8'd4, 8'd5, 8'd250, 8'd7};
    for (int i = 0; i < DEPTH; i++) step("diff_fill", 1'b1, diff_seq[i], 1'b0);
    check("diff.tap_a", 32'(tap_a), 32'd10);
    check("diff.tap_b", 32'(tap_b), 32'd250);
    step("diff_next", 1'b0, 8'd0, 1'b0);
`ifdef TAP_DIFF_EN
    check("diff.abs_diff",   32'(abs_diff),   32'd240);
    check("diff.diff_sign",  32'(diff_sign),  32'd1);
    check("diff.diff_valid", 32'(diff_valid), 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 9) < 7),
           DATA_W'($urandom),
           ($urandom_range(0, 39) == 0));
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
